// File: rtl/test_status_reporter_pkg.sv
// ---------------------------------------------------------------------------
// test_status_pkg
// Shared types and constants for the test status reporter slice.
//   state_e               : reporter FSM states (RUN, DRAIN, DONE)
//   TIMEOUT_CODE_ALL_ONES : when set, a watchdog expiry latches an all-ones
//                           exit code; otherwise it latches zero
//   PASS_PREFIX/FAIL_PREFIX : banners printed to the simulator log
// ---------------------------------------------------------------------------
package test_status_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam bit TIMEOUT_CODE_ALL_ONES = 1'b1;

    localparam string PASS_PREFIX = "*** PASSED ***";
    localparam string FAIL_PREFIX = "*** FAILED ***";

endpackage

// File: rtl/test_status_reporter_if.sv
// ---------------------------------------------------------------------------
// test_status_reporter_if
// Exit-code handshake and heartbeat between the design under test (master)
// and the status reporter (slave).
//   code_valid : exit code offered by the master
//   code_ready : reporter accepts a code this cycle
//   code_bits  : exit code payload, 0 = pass
//   heartbeat  : design-alive pulse feeding the watchdog
// ---------------------------------------------------------------------------
interface test_status_reporter_if #(
    parameter int CODE_WIDTH = 32
);

    logic                  code_valid;
    logic                  code_ready;
    logic [CODE_WIDTH-1:0] code_bits;
    logic                  heartbeat;

    modport master (
        output code_valid,
        output code_bits,
        output heartbeat,
        input  code_ready
    );

    modport slave (
        input  code_valid,
        input  code_bits,
        input  heartbeat,
        output code_ready
    );

endinterface

// File: rtl/test_status_reporter_sat_counter.sv
// ---------------------------------------------------------------------------
// test_status_sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clock, reset_n : clock and asynchronous active-low reset
//   clear          : synchronous clear, takes priority over enable
//   enable         : count up by one when not already saturated
//   count          : current count value
// ---------------------------------------------------------------------------
module test_status_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear wins, otherwise advance unless already pinned at the top.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register, cleared immediately whenever reset is asserted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/test_status_reporter.sv
// ---------------------------------------------------------------------------
// test_status_reporter
// Accepts the final exit code of the design under test, runs a heartbeat
// watchdog, waits a drain window and then raises a sticky done flag while
// reporting pass/fail to the simulator log.
//
// Ports:
//   clock, reset_n : clock (rising edge) and asynchronous active-low reset
//   code_if        : slave side of the exit-code handshake and heartbeat
//   done           : sticky test-complete flag
//   exit_code      : latched final code (all-ones after a watchdog expiry)
//   timed_out      : watchdog fired before a code arrived
//   cycle_count    : cycles since reset, saturating, frozen once done
//
// Build option: define TEST_STATUS_FINISH_EN to end the simulation one cycle
// after done rises ($finish on a zero code, $fatal otherwise). Without it the
// block only reports and the harness owns termination.
//
// CNT_WIDTH must be wide enough to hold DRAIN_CYCLES and TIMEOUT_CYCLES-1.
// ---------------------------------------------------------------------------
module test_status_reporter
    import test_status_pkg::*;
#(
    parameter int CODE_WIDTH     = 32,
    parameter int DRAIN_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    test_status_reporter_if.slave code_if,
    output logic                  done,
    output logic [CODE_WIDTH-1:0] exit_code,
    output logic                  timed_out,
    output logic [CNT_WIDTH-1:0]  cycle_count
);

    localparam bit                    WATCHDOG_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0]  DRAIN_LAST   = CNT_WIDTH'(DRAIN_CYCLES);
    localparam logic [CNT_WIDTH-1:0]  IDLE_LAST    = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CODE_WIDTH-1:0] TIMEOUT_CODE = {CODE_WIDTH{TIMEOUT_CODE_ALL_ONES}};

    state_e                state_q;
    state_e                state_d;
    logic [CODE_WIDTH-1:0] exitCode_q;
    logic [CODE_WIDTH-1:0] exitCode_d;
    logic                  timedOut_q;
    logic                  timedOut_d;
    logic [CNT_WIDTH-1:0]  idleCount;
    logic [CNT_WIDTH-1:0]  drainCount;
    logic                  accept;
    logic                  timeoutHit;

    assign code_if.code_ready = (state_q == RUN);
    assign accept             = code_if.code_valid && (state_q == RUN);

    // The watchdog fires on the last idle cycle only if no heartbeat arrives
    // in that same cycle.
    assign timeoutHit = WATCHDOG_EN && (state_q == RUN) && !code_if.heartbeat
                        && (idleCount == IDLE_LAST);

    // Elapsed-cycle counter keeps running through RUN and DRAIN and freezes in DONE.
    test_status_sat_counter #(.WIDTH(CNT_WIDTH)) cycleCounter (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (1'b0),
        .enable  (state_q != DONE),
        .count   (cycle_count)
    );

    // Idle counter measures heartbeat-free cycles; it only matters in RUN.
    test_status_sat_counter #(.WIDTH(CNT_WIDTH)) idleCounter (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (code_if.heartbeat || (state_q != RUN)),
        .enable  (state_q == RUN),
        .count   (idleCount)
    );

    // Drain counter starts at zero on the first DRAIN cycle; DRAIN exits when it
    // reaches DRAIN_CYCLES, so done lands DRAIN_CYCLES+1 edges after acceptance.
    test_status_sat_counter #(.WIDTH(CNT_WIDTH)) drainCounter (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (state_q != DRAIN),
        .enable  (state_q == DRAIN),
        .count   (drainCount)
    );

    // Next-state logic: a handshake beats a simultaneous timeout, and the
    // latched code is only ever written on the way out of RUN.
    always_comb begin
        state_d    = state_q;
        exitCode_d = exitCode_q;
        timedOut_d = timedOut_q;
        case (state_q)
            RUN: begin
                if (accept) begin
                    exitCode_d = code_if.code_bits;
                    state_d    = DRAIN;
                end else if (timeoutHit) begin
                    exitCode_d = TIMEOUT_CODE;
                    timedOut_d = 1'b1;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                if (drainCount == DRAIN_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State and result registers, cleared asynchronously by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RUN;
            exitCode_q <= '0;
            timedOut_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            exitCode_q <= exitCode_d;
            timedOut_q <= timedOut_d;
        end
    end

    assign done      = (state_q == DONE);
    assign exit_code = exitCode_q;
    assign timed_out = timedOut_q;

`ifndef SYNTHESIS
    logic [CNT_WIDTH-1:0] finalCount;
    logic                 enterDone;

    assign enterDone  = (state_q == DRAIN) && (state_d == DONE);
    assign finalCount = (cycle_count == '1) ? cycle_count : cycle_count + CNT_WIDTH'(1);

    // Print the verdict once, on the edge that moves DRAIN into DONE, showing
    // the cycle count as it will read once done is visible.
    always_ff @(posedge clock) begin
        if (reset_n && enterDone) begin
            if (exitCode_q == '0) begin
                $display("%s after %0d cycles", PASS_PREFIX, finalCount);
            end else begin
                $display("%s code=0x%0h timeout=%0d", FAIL_PREFIX, exitCode_q, timedOut_q);
            end
        end
    end

`ifdef TEST_STATUS_FINISH_EN
    logic finishPending_q;

    // Arm on the DONE entry edge and end the simulation on the following edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            finishPending_q <= 1'b0;
        end else begin
            finishPending_q <= enterDone;
            if (finishPending_q) begin
                if (exitCode_q == '0) begin
                    $finish;
                end else begin
                    $fatal(1, "%s code=0x%0h timeout=%0d", FAIL_PREFIX, exitCode_q, timedOut_q);
                end
            end
        end
    end
`endif
`endif

endmodule

// File: tb/tb_test_status_reporter.sv
// ---------------------------------------------------------------------------
// tb_test_status_reporter
// Directed bench for test_status_reporter using three configurations:
//   dutA : DRAIN_CYCLES=4, watchdog off, 32-bit counters
//   dutB : DRAIN_CYCLES=4, TIMEOUT_CYCLES=8
//   dutC : DRAIN_CYCLES=0, watchdog off, 4-bit counters
// Each configuration has its own reset so an idle one never finishes on its own.
// ---------------------------------------------------------------------------
module tb_test_status_reporter;

    logic clock = 1'b0;
    logic rstA_n = 1'b0;
    logic rstB_n = 1'b0;
    logic rstC_n = 1'b0;

    int vectorCount = 0;
    int missCount   = 0;

    logic        doneA, doneB, doneC;
    logic [31:0] exitA, exitB, exitC;
    logic        toA, toB, toC;
    logic [31:0] cntA, cntB;
    logic [3:0]  cntC;

    test_status_reporter_if #(.CODE_WIDTH(32)) ifA ();
    test_status_reporter_if #(.CODE_WIDTH(32)) ifB ();
    test_status_reporter_if #(.CODE_WIDTH(32)) ifC ();

    always #5 clock = ~clock;

    test_status_reporter #(.CODE_WIDTH(32), .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(0), .CNT_WIDTH(32)) dutA (
        .clock(clock), .reset_n(rstA_n), .code_if(ifA),
        .done(doneA), .exit_code(exitA), .timed_out(toA), .cycle_count(cntA)
    );

    test_status_reporter #(.CODE_WIDTH(32), .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(8), .CNT_WIDTH(32)) dutB (
        .clock(clock), .reset_n(rstB_n), .code_if(ifB),
        .done(doneB), .exit_code(exitB), .timed_out(toB), .cycle_count(cntB)
    );

    test_status_reporter #(.CODE_WIDTH(32), .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(0), .CNT_WIDTH(4)) dutC (
        .clock(clock), .reset_n(rstC_n), .code_if(ifC),
        .done(doneC), .exit_code(exitC), .timed_out(toC), .cycle_count(cntC)
    );

    // Single comparison point: counts every check and reports any miscompare.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectorCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance a number of rising edges, leaving time 1 unit past the last edge.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Assert every reset, then release only the selected instances so the next
    // rising edge is edge 1 of the run.
    task automatic applyReset(input bit relA, input bit relB, input bit relC);
        rstA_n = 1'b0;
        rstB_n = 1'b0;
        rstC_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        rstA_n = relA;
        rstB_n = relB;
        rstC_n = relC;
    endtask

    // Directed scenarios: reset state, pass path, back-pressure with mid-drain
    // reset and re-run, watchdog expiry/prevention/collision, edge parameters.
    initial begin
        ifA.code_valid = 1'b0; ifA.code_bits = '0; ifA.heartbeat = 1'b0;
        ifB.code_valid = 1'b0; ifB.code_bits = '0; ifB.heartbeat = 1'b0;
        ifC.code_valid = 1'b0; ifC.code_bits = '0; ifC.heartbeat = 1'b0;

        #2;
        checkOutput("rstA_done",  32'(doneA), 32'd0);
        checkOutput("rstA_exit",  exitA, 32'd0);
        checkOutput("rstA_to",    32'(toA), 32'd0);
        checkOutput("rstA_cnt",   cntA, 32'd0);
        checkOutput("rstA_ready", 32'(ifA.code_ready), 32'd1);
        checkOutput("rstB_ready", 32'(ifB.code_ready), 32'd1);
        checkOutput("rstC_cnt",   32'(cntC), 32'd0);

        $display("[TB] pass path on dutA");
        applyReset(1'b1, 1'b0, 1'b0);
        applyStimulus(9);
        ifA.code_valid = 1'b1;
        ifA.code_bits  = 32'h0;
        checkOutput("passReadyRun", 32'(ifA.code_ready), 32'd1);
        applyStimulus(1);
        ifA.code_valid = 1'b0;
        checkOutput("passReadyDrain", 32'(ifA.code_ready), 32'd0);
        checkOutput("passCntAccept",  cntA, 32'd10);
        applyStimulus(4);
        checkOutput("passDoneEarly", 32'(doneA), 32'd0);
        applyStimulus(1);
        checkOutput("passDone",  32'(doneA), 32'd1);
        checkOutput("passExit",  exitA, 32'd0);
        checkOutput("passTo",    32'(toA), 32'd0);
        checkOutput("passCnt",   cntA, 32'd15);
        applyStimulus(3);
        checkOutput("passCntFrozen", cntA, 32'd15);
        checkOutput("passDoneHeld",  32'(doneA), 32'd1);
        checkOutput("passReadyDone", 32'(ifA.code_ready), 32'd0);

        $display("[TB] back-pressure and mid-drain reset on dutA");
        applyReset(1'b1, 1'b0, 1'b0);
        applyStimulus(2);
        ifA.code_valid = 1'b1;
        ifA.code_bits  = 32'h5;
        applyStimulus(1);
        ifA.code_bits  = 32'h9;
        checkOutput("bpReady0", 32'(ifA.code_ready), 32'd0);
        applyStimulus(3);
        checkOutput("bpReady1", 32'(ifA.code_ready), 32'd0);
        checkOutput("bpExit",   exitA, 32'h5);
        checkOutput("bpDone",   32'(doneA), 32'd0);
        rstA_n = 1'b0;
        #2;
        checkOutput("midRstDone",  32'(doneA), 32'd0);
        checkOutput("midRstExit",  exitA, 32'd0);
        checkOutput("midRstCnt",   cntA, 32'd0);
        checkOutput("midRstReady", 32'(ifA.code_ready), 32'd1);
        ifA.code_valid = 1'b0;
        ifA.code_bits  = 32'h0;
        applyReset(1'b1, 1'b0, 1'b0);
        applyStimulus(2);
        ifA.code_valid = 1'b1;
        applyStimulus(1);
        ifA.code_valid = 1'b0;
        applyStimulus(4);
        checkOutput("rerunDoneEarly", 32'(doneA), 32'd0);
        applyStimulus(1);
        checkOutput("rerunDone", 32'(doneA), 32'd1);
        checkOutput("rerunExit", exitA, 32'd0);
        checkOutput("rerunCnt",  cntA, 32'd8);

        $display("[TB] watchdog expiry on dutB");
        applyReset(1'b0, 1'b1, 1'b0);
        applyStimulus(7);
        checkOutput("wdNotYet", 32'(toB), 32'd0);
        checkOutput("wdReady",  32'(ifB.code_ready), 32'd1);
        applyStimulus(1);
        checkOutput("wdFired", 32'(toB), 32'd1);
        checkOutput("wdExit",  exitB, 32'hFFFF_FFFF);
        checkOutput("wdDrain", 32'(ifB.code_ready), 32'd0);
        applyStimulus(3);
        checkOutput("wdExitHeld", exitB, 32'hFFFF_FFFF);

        $display("[TB] heartbeat on the last idle cycle on dutB");
        applyReset(1'b0, 1'b1, 1'b0);
        applyStimulus(7);
        ifB.heartbeat = 1'b1;
        applyStimulus(1);
        ifB.heartbeat = 1'b0;
        checkOutput("hbPrevent", 32'(toB), 32'd0);
        checkOutput("hbReady",   32'(ifB.code_ready), 32'd1);
        applyStimulus(7);
        checkOutput("hbRestart", 32'(toB), 32'd0);
        applyStimulus(1);
        checkOutput("hbLater", 32'(toB), 32'd1);

        $display("[TB] handshake on the timeout cycle on dutB");
        applyReset(1'b0, 1'b1, 1'b0);
        applyStimulus(7);
        ifB.code_valid = 1'b1;
        ifB.code_bits  = 32'h3;
        applyStimulus(1);
        ifB.code_valid = 1'b0;
        checkOutput("colExit",  exitB, 32'h3);
        checkOutput("colTo",    32'(toB), 32'd0);
        checkOutput("colReady", 32'(ifB.code_ready), 32'd0);
        applyStimulus(3);
        checkOutput("colToHeld", 32'(toB), 32'd0);

        $display("[TB] saturation and zero drain on dutC");
        applyReset(1'b0, 1'b0, 1'b1);
        applyStimulus(20);
        checkOutput("satCnt",   32'(cntC), 32'd15);
        checkOutput("satReady", 32'(ifC.code_ready), 32'd1);
        checkOutput("satDone",  32'(doneC), 32'd0);
        ifC.code_valid = 1'b1;
        ifC.code_bits  = 32'h0;
        applyStimulus(1);
        ifC.code_valid = 1'b0;
        checkOutput("zdReady", 32'(ifC.code_ready), 32'd0);
        checkOutput("zdEarly", 32'(doneC), 32'd0);
        applyStimulus(1);
        checkOutput("zdDone", 32'(doneC), 32'd1);
        checkOutput("zdExit", exitC, 32'd0);
        checkOutput("zdTo",   32'(toC), 32'd0);
        checkOutput("zdCnt",  32'(cntC), 32'd15);

        rstA_n = 1'b0;
        rstB_n = 1'b0;
        rstC_n = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
